mem_arbiter: RTL

Shares the single-port instruction/data memory between the fetch path and the load/store path of the processor. Each cycle it arbitrates one memory access and drives the memory port. It tracks the outstanding read's fixed latency and routes read data back to the requester that issued it. Data accesses normally win; a starvation counter guarantees forward progress for fetch.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data accesses take priority over instruction fetch,
// with a starvation counter that forces a fetch grant after STARVE_MAX losses.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int              SW   = $clog2(STARVE_MAX + 1);
  localparam logic [3:0]      LAT  = 4'(MEM_LAT);
  localparam logic [SW-1:0]   SMAX = SW'(STARVE_MAX);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  owner_t        owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          d_rvalid_q, d_rvalid_d;

  logic          last_cyc;
  logic          port_free;
  logic          fetch_win;
  logic          data_win;
  logic          rd_win;

  // Arbitration: the port is free in IDLE and in the final wait cycle, and
  // nothing is granted while reset is asserted.
  always_comb begin
    last_cyc  = (state_q == WAIT) && (cnt_q == LAT);
    port_free = rst_n && ((state_q == IDLE) || last_cyc);
    fetch_win = port_free && if_req && ((starve_q == SMAX) || !d_req);
    data_win  = port_free && d_req && !fetch_win;
    rd_win    = fetch_win || (data_win && !d_we);
  end

  always_comb begin
    if_gnt    = fetch_win;
    d_gnt     = data_win;
    mem_en    = fetch_win || data_win;
    mem_we    = data_win && d_we;
    mem_addr  = '0;
    if (fetch_win) begin
      mem_addr = if_addr;
    end else if (data_win) begin
      mem_addr = d_addr;
    end
    mem_wdata = (data_win && d_we) ? d_wdata : '0;
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
    if_rvalid = if_rvalid_q;
    d_rvalid  = d_rvalid_q;
  end

  // Next-state: a read grant always (re)starts the latency count, even when
  // it lands in the last wait cycle of the previous read.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    starve_d = starve_q;

    if ((state_q == WAIT) && !last_cyc) begin
      cnt_d = cnt_q + 4'd1;
    end else if (port_free) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    if (rd_win) begin
      state_d = WAIT;
      cnt_d   = 4'd1;
      owner_d = fetch_win ? OWN_IF : OWN_D;
    end

    if (fetch_win) begin
      starve_d = '0;
    end else if (port_free && if_req && (starve_q != SMAX)) begin
      starve_d = starve_q + SW'(1);
    end

    if_rvalid_d = (state_d == WAIT) && (cnt_d == LAT) && (owner_d == OWN_IF);
    d_rvalid_d  = (state_d == WAIT) && (cnt_d == LAT) && (owner_d == OWN_D);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_IF;
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
    end
  end

endmodule
